// File: rtl/hub75_line_capture_if.sv
// Pixel beat stream produced by hub75_line_capture: one beat per captured column
// of a latched line, with a valid/ready handshake.
interface hub75_line_capture_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 6
);
    logic                pix_valid;
    logic                pix_ready;
    logic [ROW_BITS-1:0] pix_row;
    logic [COL_BITS-1:0] pix_col;
    logic [2:0]          pix_plane;
    logic [5:0]          pix_rgb;
    logic                pix_last;

    modport master (
        output pix_valid, pix_row, pix_col, pix_plane, pix_rgb, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_row, pix_col, pix_plane, pix_rgb, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/hub75_line_capture.sv
// Samples an externally driven HUB75 panel bus and replays each latched line as
// per-column pixel beats; capture and drain alternate between two line buffers.
module hub75_line_capture #(
    parameter int WIDTH    = 64,
    parameter int ROW_BITS = 5,
    parameter int PLANES   = 7
) (
    input  logic                display_clock,
    input  logic                resetn,
    input  logic                hub_clk,
    input  logic                hub_stb,
    input  logic [ROW_BITS-1:0] hub_addr,
    input  logic [5:0]          hub_rgb,
    hub75_line_capture_if.master pix,
    output logic                frame_start,
    output logic                overrun
);
    localparam int COL_BITS = $clog2(WIDTH);
    localparam int CNT_BITS = $clog2(WIDTH + 1);
    localparam int DEPTH    = 2 ** (COL_BITS + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [2:0]          clk_sync, stb_sync;
    logic [ROW_BITS-1:0] addr_s1, addr_s2, addr_q;
    logic [5:0]          rgb_s1, rgb_s2, rgb_q;
    logic                clk_rise, stb_rise;

    state_t              state;
    logic [CNT_BITS-1:0] in_cnt;
    logic                cap_sel;
    logic [ROW_BITS-1:0] last_row;
    logic                last_valid;
    logic [2:0]          plane;
    logic [COL_BITS-1:0] last_col;

    logic [5:0]          line_buf [DEPTH];

    logic                cap_wr, fire, drain_free;
    logic [CNT_BITS-1:0] lat_count;
    logic [2:0]          next_plane;
    logic [COL_BITS-1:0] rd_col;
    logic [5:0]          first_rgb;

    // Data lines get the same depth as the edge detector so a registered rise
    // pulse lines up with the row/colour value present at that rise.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '0;
            stb_sync <= '0;
            addr_s1  <= '0;
            addr_s2  <= '0;
            addr_q   <= '0;
            rgb_s1   <= '0;
            rgb_s2   <= '0;
            rgb_q    <= '0;
            clk_rise <= 1'b0;
            stb_rise <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[1:0], hub_clk};
            stb_sync <= {stb_sync[1:0], hub_stb};
            addr_s1  <= hub_addr;
            addr_s2  <= addr_s1;
            addr_q   <= addr_s2;
            rgb_s1   <= hub_rgb;
            rgb_s2   <= rgb_s1;
            rgb_q    <= rgb_s2;
            clk_rise <= clk_sync[1] & ~clk_sync[2];
            stb_rise <= stb_sync[1] & ~stb_sync[2];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cap_wr     = clk_rise && (in_cnt < CNT_BITS'(WIDTH));
        lat_count  = in_cnt + CNT_BITS'(cap_wr);
        fire       = pix.pix_valid && pix.pix_ready;
        drain_free = (state == IDLE) || (fire && pix.pix_last);
        next_plane = 3'd0;
        if (last_valid && (addr_q == last_row))
            next_plane = (plane == 3'(PLANES - 1)) ? 3'd0 : plane + 3'd1;
        rd_col     = pix.pix_col + COL_BITS'(1);
        // Column 0 may be written on the very edge that latches the line.
        first_rgb  = line_buf[{cap_sel, COL_BITS'(0)}];
        if (cap_wr && (in_cnt == '0))
            first_rgb = rgb_q;
    end

    // NOTE: the line buffers are deliberately not reset so they can map onto
    // RAM; nothing reads a column before it has been written.
    always_ff @(posedge display_clock) begin
        if (cap_wr)
            line_buf[{cap_sel, in_cnt[COL_BITS-1:0]}] <= rgb_q;
    end

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            in_cnt        <= '0;
            cap_sel       <= 1'b0;
            last_row      <= '0;
            last_valid    <= 1'b0;
            plane         <= 3'd0;
            last_col      <= '0;
            frame_start   <= 1'b0;
            overrun       <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_row   <= '0;
            pix.pix_col   <= '0;
            pix.pix_plane <= 3'd0;
            pix.pix_rgb   <= '0;
            pix.pix_last  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            overrun     <= 1'b0;

            if (cap_wr)
                in_cnt <= in_cnt + CNT_BITS'(1);

            if (fire) begin
                if (pix.pix_last) begin
                    state         <= IDLE;
                    pix.pix_valid <= 1'b0;
                    pix.pix_last  <= 1'b0;
                end else begin
                    pix.pix_col  <= rd_col;
                    pix.pix_rgb  <= line_buf[{~cap_sel, rd_col}];
                    pix.pix_last <= (rd_col == last_col);
                end
            end

            if (stb_rise) begin
                last_row    <= addr_q;
                last_valid  <= 1'b1;
                plane       <= next_plane;
                frame_start <= (addr_q == '0) && (next_plane == 3'd0);
                in_cnt      <= '0;
                // Empty lines only advance row/plane tracking.
                if (lat_count != '0) begin
                    if (drain_free) begin
                        cap_sel       <= ~cap_sel;
                        state         <= DRAIN;
                        last_col      <= COL_BITS'(lat_count - CNT_BITS'(1));
                        pix.pix_valid <= 1'b1;
                        pix.pix_row   <= addr_q;
                        pix.pix_col   <= '0;
                        pix.pix_plane <= next_plane;
                        pix.pix_rgb   <= first_rgb;
                        pix.pix_last  <= (lat_count == CNT_BITS'(1));
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hub75_line_capture.sv
// Self-checking bench for hub75_line_capture: a behavioural line/beat model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hub75_line_capture;
    localparam int WIDTH    = 64;
    localparam int ROW_BITS = 5;
    localparam int PLANES   = 7;

    typedef struct packed {
        logic [4:0] row;
        logic [5:0] col;
        logic [2:0] plane;
        logic [5:0] rgb;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic       clk;
        logic       stb;
        logic [4:0] addr;
        logic [5:0] rgb;
    } snap_t;

    logic       display_clock = 1'b0;
    logic       resetn        = 1'b0;
    logic       hub_clk       = 1'b0;
    logic       hub_stb       = 1'b0;
    logic [4:0] hub_addr      = '0;
    logic [5:0] hub_rgb       = '0;
    logic       frame_start, overrun;

    hub75_line_capture_if #(.ROW_BITS(ROW_BITS), .COL_BITS(6)) pix ();

    hub75_line_capture #(.WIDTH(WIDTH), .ROW_BITS(ROW_BITS), .PLANES(PLANES)) dut (
        .display_clock(display_clock),
        .resetn       (resetn),
        .hub_clk      (hub_clk),
        .hub_stb      (hub_stb),
        .hub_addr     (hub_addr),
        .hub_rgb      (hub_rgb),
        .pix          (pix),
        .frame_start  (frame_start),
        .overrun      (overrun)
    );

    always #5 display_clock = ~display_clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: captured columns of the line being shifted, expected beats
    // still to be transferred, and the row/plane tracking.
    logic [5:0] cap_q[$];
    beat_t      exp_q[$];
    snap_t      hist[5];
    logic [4:0] m_last_row;
    logic       m_last_valid;
    int         m_plane;
    logic       exp_fs, exp_ov;

    beat_t      log_q[$];
    int         fs_cnt = 0;
    int         ov_cnt = 0;

    // An input edge first sampled at clock edge t takes effect at edge t+3.
    initial begin : model
        forever begin
            @(negedge display_clock);
            if (!resetn) begin
                cap_q.delete();
                exp_q.delete();
                for (int i = 0; i < 5; i++) hist[i] = '0;
                m_last_row   = '0;
                m_last_valid = 1'b0;
                m_plane      = 0;
                exp_fs       = 1'b0;
                exp_ov       = 1'b0;
                check("reset_outputs",
                      {pix.pix_valid, pix.pix_row, pix.pix_col, pix.pix_plane,
                       pix.pix_rgb, pix.pix_last, frame_start, overrun}, 0);
            end else begin
                check("pix_valid", pix.pix_valid, exp_q.size() > 0);
                if (exp_q.size() > 0)
                    check("beat", {pix.pix_row, pix.pix_col, pix.pix_plane, pix.pix_rgb, pix.pix_last},
                          exp_q[0]);
                check("frame_start", frame_start, exp_fs);
                check("overrun", overrun, exp_ov);

                if (pix.pix_valid && pix.pix_ready)
                    log_q.push_back({pix.pix_row, pix.pix_col, pix.pix_plane, pix.pix_rgb, pix.pix_last});
                if (frame_start) fs_cnt++;
                if (overrun) ov_cnt++;

                for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {hub_clk, hub_stb, hub_addr, hub_rgb};
                exp_fs = 1'b0;
                exp_ov = 1'b0;
                if (exp_q.size() > 0 && pix.pix_ready)
                    void'(exp_q.pop_front());
                if (hist[3].clk && !hist[4].clk && cap_q.size() < WIDTH)
                    cap_q.push_back(hist[3].rgb);
                if (hist[3].stb && !hist[4].stb) begin
                    if (m_last_valid && hist[3].addr == m_last_row) m_plane = (m_plane + 1) % PLANES;
                    else m_plane = 0;
                    m_last_row   = hist[3].addr;
                    m_last_valid = 1'b1;
                    exp_fs       = (hist[3].addr == 0) && (m_plane == 0);
                    if (cap_q.size() > 0) begin
                        if (exp_q.size() == 0) begin
                            for (int c = 0; c < cap_q.size(); c++) begin
                                beat_t b;
                                b.row   = hist[3].addr;
                                b.col   = 6'(c);
                                b.plane = 3'(m_plane);
                                b.rgb   = cap_q[c];
                                b.last  = (c == cap_q.size() - 1);
                                exp_q.push_back(b);
                            end
                        end else begin
                            exp_ov = 1'b1;
                        end
                        cap_q.delete();
                    end
                end
            end
        end
    end

    int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
    initial begin : ready_drv
        pix.pix_ready = 1'b0;
        forever begin
            @(posedge display_clock);
            #1;
            case (ready_mode)
                0:       pix.pix_ready = 1'b1;
                1:       pix.pix_ready = 1'b0;
                default: pix.pix_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge display_clock);
        #1;
    endtask

    task automatic shift_col(input logic [5:0] rgb);
        hub_rgb = rgb;
        tick();
        hub_clk = 1'b1;
        repeat (2) tick();
        hub_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic strobe(input logic [4:0] row);
        hub_addr = row;
        tick();
        hub_stb = 1'b1;
        repeat (2) tick();
        hub_stb = 1'b0;
        repeat (2) tick();
    endtask

    // Last shift-clock rise and strobe rise land on the same sampling edge.
    task automatic shift_strobe(input logic [5:0] rgb, input logic [4:0] row);
        hub_rgb  = rgb;
        hub_addr = row;
        tick();
        hub_clk = 1'b1;
        hub_stb = 1'b1;
        repeat (2) tick();
        hub_clk = 1'b0;
        hub_stb = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        repeat (4) tick();
        while (exp_q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin : stim
        int         log0, fs0, ov0, seen, bad, n;
        logic [4:0] row;
        logic       same;
        logic [2:0] planes_exp [9];

        planes_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};

        resetn = 1'b0;
        repeat (4) tick();
        check("rst_valid", pix.pix_valid, 0);
        check("rst_frame_start", frame_start, 0);
        resetn = 1'b1;
        repeat (2) tick();

        // Plane sequencing: eight lines on row 0, then one on row 1.
        ready_mode = 0;
        log0 = log_q.size();
        fs0  = fs_cnt;
        for (int k = 0; k < 9; k++) begin
            shift_col(6'(k));
            shift_col(6'(k + 1));
            strobe((k == 8) ? 5'd1 : 5'd0);
            wait_drain("plane_seq");
        end
        seen = 0;
        for (int i = log0; i < log_q.size(); i++) begin
            if (log_q[i].col == 0) begin
                if (seen < 9) check("plane_seq_plane", log_q[i].plane, planes_exp[seen]);
                seen++;
            end
        end
        check("plane_seq_lines", seen, 9);
        check("plane_seq_frame_starts", fs_cnt - fs0, 2);

        // Full line on row 3.
        log0 = log_q.size();
        ov0  = ov_cnt;
        for (int c = 0; c < 64; c++) shift_col(6'(c));
        strobe(5'd3);
        wait_drain("full");
        check("full_beats", log_q.size() - log0, 64);
        if (log_q.size() - log0 == 64) begin
            bad = 0;
            for (int c = 0; c < 64; c++)
                if (log_q[log0 + c].col != 6'(c) || log_q[log0 + c].rgb != 6'(c)) bad++;
            check("full_order", bad, 0);
            check("full_first", log_q[log0], {5'd3, 6'd0, 3'd0, 6'd0, 1'b0});
            check("full_last", log_q[log0 + 63], {5'd3, 6'd63, 3'd0, 6'd63, 1'b1});
        end
        check("full_no_overrun", ov_cnt - ov0, 0);

        // Backpressure: line B arrives while line A is still stalled.
        ready_mode = 1;
        tick();
        log0 = log_q.size();
        ov0  = ov_cnt;
        for (int c = 0; c < 64; c++) shift_col(6'(c) ^ 6'h2A);
        strobe(5'd5);
        for (int c = 0; c < 64; c++) shift_col(~6'(c));
        strobe(5'd5);
        repeat (2) tick();
        check("bp_overrun", ov_cnt - ov0, 1);
        check("bp_frozen_valid", pix.pix_valid, 1);
        check("bp_frozen_col", pix.pix_col, 0);
        check("bp_frozen_rgb", pix.pix_rgb, 6'h2A);
        ready_mode = 0;
        wait_drain("bp");
        check("bp_beats", log_q.size() - log0, 64);
        if (log_q.size() - log0 == 64)
            check("bp_last", log_q[log0 + 63], {5'd5, 6'd63, 3'd0, 6'h15, 1'b1});

        // Short line, empty line, then a one-column line on the same row.
        log0 = log_q.size();
        for (int c = 0; c < 10; c++) shift_col(6'(c + 1));
        strobe(5'd7);
        wait_drain("short");
        check("short_beats", log_q.size() - log0, 10);
        if (log_q.size() - log0 == 10)
            check("short_last", log_q[log0 + 9], {5'd7, 6'd9, 3'd0, 6'd10, 1'b1});
        log0 = log_q.size();
        strobe(5'd7);
        wait_drain("empty");
        check("empty_beats", log_q.size() - log0, 0);
        shift_col(6'h33);
        strobe(5'd7);
        wait_drain("after_empty");
        check("after_empty_beats", log_q.size() - log0, 1);
        if (log_q.size() - log0 == 1)
            check("after_empty_beat", log_q[log0], {5'd7, 6'd0, 3'd2, 6'h33, 1'b1});

        // Excess shift clocks: only the first 64 columns are kept.
        log0 = log_q.size();
        for (int c = 0; c < 70; c++) shift_col(6'(c));
        strobe(5'd9);
        wait_drain("excess");
        check("excess_beats", log_q.size() - log0, 64);
        if (log_q.size() - log0 == 64) begin
            check("excess_col5", log_q[log0 + 5].rgb, 6'd5);
            check("excess_last", log_q[log0 + 63], {5'd9, 6'd63, 3'd0, 6'd63, 1'b1});
        end

        // Reset while column 20 is on the bus.
        for (int c = 0; c < 64; c++) shift_col(6'(c));
        strobe(5'd9);
        n = 0;
        while (!(pix.pix_valid && pix.pix_col == 6'd20) && n < 200) begin
            tick();
            n++;
        end
        check("rst_mid_reached_col20", {pix.pix_valid, pix.pix_col, pix.pix_plane}, {1'b1, 6'd20, 3'd1});
        resetn = 1'b0;
        #1;
        check("rst_mid_outputs",
              {pix.pix_valid, pix.pix_row, pix.pix_col, pix.pix_plane, pix.pix_rgb, pix.pix_last}, 0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();
        log0 = log_q.size();
        for (int c = 0; c < 4; c++) shift_col(6'(c + 8));
        strobe(5'd9);
        wait_drain("post_reset");
        check("post_reset_beats", log_q.size() - log0, 4);
        if (log_q.size() - log0 == 4)
            check("post_reset_first", log_q[log0], {5'd9, 6'd0, 3'd0, 6'd8, 1'b0});

        // Randomised lines, random backpressure, occasional coincident strobe.
        ready_mode = 2;
        for (int l = 0; l < 24; l++) begin
            n = $urandom_range(70);
            if ($urandom_range(3) == 0) n = $urandom_range(3);
            row  = 5'($urandom_range(1));
            same = ($urandom_range(3) == 0) && (n > 0);
            for (int c = 0; c < n; c++) begin
                if (same && c == n - 1) shift_strobe(6'($urandom), row);
                else shift_col(6'($urandom));
            end
            if (!same) strobe(row);
            repeat ($urandom_range(60)) tick();
        end
        ready_mode = 0;
        wait_drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hub75_line_capture.md
# hub75_line_capture

Receive-side counterpart of the LED panel driver: samples a HUB75 panel bus (shift clock, strobe, row address, six colour lines) driven by an external source and reconstructs each latched line as a stream of per-column, per-bit-plane pixel beats. It sits between the panel connector pins and a downstream plane accumulator or frame buffer. Typical uses are cascading cubes and loop-back checking of the panel driver on hardware. Capture and drain are ping-ponged, so one line can drain while the next is shifted in.

## Interface
- WIDTH, 64: columns per line; maximum shift-clock edges captured per strobe.
- ROW_BITS, 5: width of the row-select bus {e,d,c,b,a}.
- PLANES, 7: bit planes per row; the plane counter wraps modulo PLANES.
- display_clock  in  1  sole clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- hub_clk  in  1  panel shift clock; asynchronous to display_clock.
- hub_stb  in  1  panel latch strobe, active high.
- hub_addr  in  ROW_BITS  row select {e,d,c,b,a}.
- hub_rgb  in  6  colour lines {b1,b0,g1,g0,r1,r0}: bits 0/2/4 for the top half, bits 1/3/5 for the bottom half (row+16).
- pix_valid  out  1  beat valid.
- pix_ready  in  1  downstream accepts the beat.
- pix_row  out  ROW_BITS  row latched with this line.
- pix_col  out  $clog2(WIDTH)  column index, equal to shift order (the first edge after a strobe is column 0).
- pix_plane  out  3  bit-plane index of this line.
- pix_rgb  out  6  captured colour bits, in hub_rgb order.
- pix_last  out  1  final beat of the line.
- frame_start  out  1  one-cycle pulse when a line with row 0 and plane 0 is latched.
- overrun  out  1  one-cycle pulse when a latched line is dropped.

## Operation
- Input conditioning: hub_clk, hub_stb, hub_addr and hub_rgb each pass through an identical 2-FF synchronizer, which keeps data aligned with the clock. A third stage of hub_clk and hub_stb provides rising-edge detection. Source requirement: hub_clk high ≥2 and low ≥2 display_clock periods; data is stable across the hub_clk rising edge.
- Capture: on each detected hub_clk rise, the synced hub_rgb is written to capture_buf[in_cnt] and in_cnt increments. Once in_cnt == WIDTH, further edges are ignored until the next strobe.
- Latch, on a detected hub_stb rise:
  - row = synced hub_addr.
  - If row == last_row and last_row is valid, plane = (plane+1) mod PLANES; otherwise plane = 0.
  - last_row is updated and marked valid.
  - frame_start pulses when row==0 and plane==0.
- If the drain side is idle, or frees in this same cycle (final beat handshaking now), the buffers swap: the drain takes {row, plane, count=in_cnt}, and in_cnt returns to 0.
- If the drain side is busy, overrun pulses, the latched line is discarded and in_cnt returns to 0. Row/plane tracking still advances.
- Zero-length latch (in_cnt==0): row/plane tracking updates and frame_start may pulse; no beats are emitted and the drain state is unchanged.
- Drain FSM states: IDLE and DRAIN.
  - IDLE → DRAIN on swap with count>0.
  - DRAIN emits columns 0..count-1. pix_last is set on column count-1.
  - DRAIN → IDLE on the last handshake, or re-enters DRAIN directly if a swap happens in that same cycle.
- Handshake: a beat transfers when pix_valid && pix_ready. pix_* hold stable while pix_valid && !pix_ready. pix_valid never drops without a transfer.
- Reset: all outputs 0; state IDLE; in_cnt 0; last_row invalid; plane 0. Buffer contents are don't-care. A reset mid-drain aborts the line.

## Timing
- A hub_clk rise first sampled high at edge t is written to capture_buf at edge t+3.
- A hub_stb rise first sampled high at edge t gives pix_valid high after edge t+3, provided the drain is idle. frame_start and overrun pulse in the same cycle.
- With pix_ready tied high, throughput is 1 beat/cycle: a count-column line occupies the drain for exactly count cycles.
- A strobe that is synchronized in the same cycle as the last hub_clk rise includes that column (capture write takes priority over the count reset).
- Buffers: 2 × WIDTH × 6 bits, inferred as distributed or block RAM. Read latency is hidden so that pix_valid timing above holds.

## Test plan
- Full line: 64 hub_clk pulses with hub_rgb = col[5:0], then a strobe with hub_addr=3, pix_ready=1. Expect 64 beats with pix_col 0..63, pix_rgb = col, pix_row=3, pix_plane=0, pix_last on column 63, and no overrun.
- Plane sequencing: from reset, 8 lines at row 0 then 1 line at row 1. Expect planes 0,1,2,3,4,5,6,0 then 0. frame_start pulses on lines 1 and 8; row 1 gives no pulse.
- Backpressure and overrun: pix_ready=0, line A latched, line B shifted and latched. Expect overrun to pulse once at B's strobe and pix_* to stay frozen on A column 0. After pix_ready=1, only A's 64 beats appear.
- Short and empty lines: 10 clocks then a strobe gives 10 beats with pix_last at column 9. A strobe with no clocks gives no beats, but plane still advances.
- Excess clocks: 70 pulses then a strobe gives 64 beats carrying data from the first 64 pulses only.
- Reset mid-drain: resetn low during column 20 drops all outputs to 0 asynchronously. After release, the next line latches as plane 0.
